abox_inv_serial: RTL and testbench

Nibble-serial, share-wise inverse of the PRINCE TI linear layer A (4-bit map z0=x1, z1=x0^x1^x2, z2=x3, z3=x2) for the 4-share first-order masked datapath. It accepts a full 64-bit state in 4 Boolean shares, applies A⁻¹ to every nibble of every share, and returns the result. It sits on the decryption/inverse-S-box path, undoing the affine decomposition layer the encryption side applies. A is linear, so each share is transformed independently and no fresh randomness is consumed.

---
 rtl/prince_ti_pkg.sv | 18 +
 rtl/abox_inv_serial_if.sv | 24 ++
 rtl/abox_inv.sv | 15 +
 rtl/abox_inv_serial.sv | 99 +++++++++
 tb/tb_abox_inv_serial.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/prince_ti_pkg.sv
// Shared constants, FSM encoding and NPC legality helper for the
// nibble-serial PRINCE TI inverse linear layer.
package prince_ti_pkg;
  localparam int SHARES  = 4;
  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;
  localparam int BUS_W   = SHARES * STATE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit npc_legal(input int npc);
    return (npc == 1) || (npc == 2) || (npc == 4) || (npc == 8) || (npc == 16);
  endfunction
endpackage

// File: rtl/abox_inv_serial_if.sv
// Load/unload handshake bundle between a masked-state producer/consumer
// and abox_inv_serial.
interface abox_inv_serial_if;
  import prince_ti_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_shares;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_shares;
  logic             flush;
  logic             busy;

  modport slave (
    input  in_valid, in_shares, out_ready, flush,
    output in_ready, out_valid, out_shares, busy
  );

  modport master (
    output in_valid, in_shares, out_ready, flush,
    input  in_ready, out_valid, out_shares, busy
  );
endinterface

// File: rtl/abox_inv.sv
// Combinational inverse of the 4-bit TI linear layer A, applied to one
// nibble of one share.
module abox_inv
  import prince_ti_pkg::*;
(
  input  logic [3:0] z,
  output logic [3:0] x
);
  always_comb begin
    x[0] = z[0] ^ z[1] ^ z[3];
    x[1] = z[0];
    x[2] = z[3];
    x[3] = z[2];
  end
endmodule

// File: rtl/abox_inv_serial.sv
// Nibble-serial share-wise A^-1 over a 4-share 64-bit state; NPC nibbles of
// every share are rewritten in place per RUN cycle.
module abox_inv_serial
  import prince_ti_pkg::*;
#(
  parameter int NPC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  abox_inv_serial_if.slave  bus
);
  localparam int NSTEP   = NIBBLES / NPC;
  localparam int CW      = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int CHUNK_W = 4 * NPC;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  if (!npc_legal(NPC)) begin : g_bad_npc
    $error("abox_inv_serial: NPC must divide 16 (1, 2, 4, 8 or 16)");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BUS_W-1:0] sreg_q, sreg_d;
  logic [BUS_W-1:0] xf;
  logic             last;

  logic [SHARES-1:0][CHUNK_W-1:0] chunk_z, chunk_x;

  // With NPC=16 the counter is a constant-zero bit and RUN is a single step.
  assign last = (cnt_q == CW'(NSTEP - 1));

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    assign chunk_z[s] = sreg_q[s*STATE_W + int'(cnt_q)*CHUNK_W +: CHUNK_W];
    for (genvar j = 0; j < NPC; j++) begin : g_nib
      abox_inv u_abox_inv (
        .z (chunk_z[s][4*j +: 4]),
        .x (chunk_x[s][4*j +: 4])
      );
    end
  end

  always_comb begin
    xf = sreg_q;
    for (int s = 0; s < SHARES; s++) begin
      xf[s*STATE_W + int'(cnt_q)*CHUNK_W +: CHUNK_W] = chunk_x[s];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sreg_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sreg_d  = bus.in_shares;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          sreg_d = xf;
          if (last) state_d = ST_DONE;
          else      cnt_d   = cnt_q + 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  // Outputs decode only registered state, so reset reaches them asynchronously.
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.out_shares = (state_q == ST_DONE) ? sreg_q : '0;
endmodule

// File: tb/tb_abox_inv_serial.sv
// Directed and randomized checks of abox_inv_serial for NPC = 1, 2, 4, 8, 16.
module tb_abox_inv_serial;
  import prince_ti_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             in_valid_v [5];
  logic [BUS_W-1:0] in_shares;
  logic             out_ready;
  logic             flush;
  logic             in_ready_v [5];
  logic             out_valid_v [5];
  logic             busy_v [5];
  logic [BUS_W-1:0] out_shares_v [5];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    abox_inv_serial_if u_if ();
    assign u_if.in_valid  = in_valid_v[g];
    assign u_if.in_shares = in_shares;
    assign u_if.out_ready = out_ready;
    assign u_if.flush     = flush;
    assign in_ready_v[g]   = u_if.in_ready;
    assign out_valid_v[g]  = u_if.out_valid;
    assign busy_v[g]       = u_if.busy;
    assign out_shares_v[g] = u_if.out_shares;
    abox_inv_serial #(.NPC(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
    );
  end

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_ainv(input logic [3:0] z);
    return {z[2], z[3], z[0], z[0] ^ z[1] ^ z[3]};
  endfunction

  function automatic logic [BUS_W-1:0] m_state(input logic [BUS_W-1:0] s);
    logic [BUS_W-1:0] r;
    for (int i = 0; i < BUS_W / 4; i++) r[4*i +: 4] = m_ainv(s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] fold(input logic [BUS_W-1:0] s);
    return s[0 +: 64] ^ s[64 +: 64] ^ s[128 +: 64] ^ s[192 +: 64];
  endfunction

  function automatic logic [STATE_W-1:0] m_share(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    for (int i = 0; i < NIBBLES; i++) r[4*i +: 4] = m_ainv(s[4*i +: 4]);
    return r;
  endfunction

  task automatic send(input int g, input logic [BUS_W-1:0] sh, output int lat, output logic [BUS_W-1:0] res);
    @(negedge clk);
    in_shares     = sh;
    in_valid_v[g] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid_v[g] = 1'b0;
      in_shares     = '0;
    end while (!out_valid_v[g] && lat < 40);
    res = out_shares_v[g];
    if (lat >= 40) check("timeout", BUS_W'(out_valid_v[g]), BUS_W'(1));
  endtask

  initial begin
    int lat;
    int lats [5];
    logic [BUS_W-1:0] res, held, rnd;
    logic [BUS_W-1:0] res_v [5];
    logic [63:0] sweep_in  [4];
    logic [63:0] sweep_out [4];
    int rose;

    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0; in_shares = '0;
    for (int g = 0; g < 5; g++) in_valid_v[g] = 1'b0;
    #1;
    check("rst_in_ready",   BUS_W'(in_ready_v[0]),  BUS_W'(1));
    check("rst_out_valid",  BUS_W'(out_valid_v[0]), BUS_W'(0));
    check("rst_busy",       BUS_W'(busy_v[0]),      BUS_W'(0));
    check("rst_out_shares", out_shares_v[0],        '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(0, BUS_W'(64'h1), lat, res);
    check("single_nib_lat", BUS_W'(lat), BUS_W'(17));
    check("single_nib_res", res, BUS_W'(64'h3));

    sweep_in[0] = 64'hFFFF_FFFF_FFFF_FFFF; sweep_out[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    sweep_in[1] = 64'h8888_8888_8888_8888; sweep_out[1] = 64'h5555_5555_5555_5555;
    sweep_in[2] = 64'h4444_4444_4444_4444; sweep_out[2] = 64'h8888_8888_8888_8888;
    sweep_in[3] = 64'h2222_2222_2222_2222; sweep_out[3] = 64'h1111_1111_1111_1111;
    for (int k = 0; k < 4; k++) begin
      send(0, BUS_W'(sweep_in[k]), lat, res);
      check($sformatf("sweep%0d", k), res, BUS_W'(sweep_out[k]));
    end

    // All five NPC variants get the same random state in the same cycle.
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 8; w++) rnd[32*w +: 32] = $urandom;
      @(negedge clk);
      in_shares = rnd;
      for (int g = 0; g < 5; g++) begin in_valid_v[g] = 1'b1; lats[g] = 0; end
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
          in_valid_v[g] = 1'b0;
          if (out_valid_v[g] && lats[g] == 0) begin lats[g] = k; res_v[g] = out_shares_v[g]; end
        end
        in_shares = '0;
      end
      for (int g = 0; g < 5; g++) begin
        check($sformatf("rnd%0d_npc%0d_lat", t, 1 << g), BUS_W'(lats[g]), BUS_W'((16 >> g) + 1));
        check($sformatf("rnd%0d_npc%0d_shares", t, 1 << g), res_v[g], m_state(rnd));
        check($sformatf("rnd%0d_npc%0d_xor", t, 1 << g), BUS_W'(fold(res_v[g])), BUS_W'(m_share(fold(rnd))));
      end
    end

    // Backpressure with a competing in_valid held during DONE.
    out_ready = 1'b0;
    send(0, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_1234_8421, 64'hDEAD_BEEF_CAFE_F00D}, lat, held);
    check("bp_first", held, m_state({64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_1234_8421, 64'hDEAD_BEEF_CAFE_F00D}));
    in_valid_v[0] = 1'b1;
    in_shares = {4{64'h1111_2222_3333_4444}};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid",    BUS_W'(out_valid_v[0]), BUS_W'(1));
      check("bp_in_ready", BUS_W'(in_ready_v[0]),  BUS_W'(0));
      check("bp_stable",   out_shares_v[0],        held);
    end
    in_valid_v[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", BUS_W'(in_ready_v[0]),  BUS_W'(1));
    check("bp_release_valid", BUS_W'(out_valid_v[0]), BUS_W'(0));
    @(negedge clk);
    check("bp_second_ignored", BUS_W'(busy_v[0]), BUS_W'(0));

    // Flush during RUN cycle 5.
    @(negedge clk);
    in_shares = BUS_W'(64'hFFFF_FFFF_FFFF_FFFF);
    in_valid_v[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid_v[0] = 1'b0;
    end
    check("flush_pre_busy", BUS_W'(busy_v[0]), BUS_W'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",     BUS_W'(busy_v[0]),     BUS_W'(0));
    check("flush_in_ready", BUS_W'(in_ready_v[0]), BUS_W'(1));
    check("flush_out",      out_shares_v[0],       '0);
    rose = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_v[0]) rose = 1;
    end
    check("flush_no_valid", BUS_W'(rose), BUS_W'(0));
    send(0, BUS_W'(64'h8421_0000_0000_0001), lat, res);
    check("flush_recover", res, BUS_W'(64'h5813_0000_0000_0003));

    // Asynchronous reset mid-RUN, away from any clock edge.
    @(negedge clk);
    in_shares = BUS_W'(64'h2);
    in_valid_v[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      in_valid_v[0] = 1'b0;
    end
    check("arst_pre_busy", BUS_W'(busy_v[0]), BUS_W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",     BUS_W'(busy_v[0]),      BUS_W'(0));
    check("arst_in_ready", BUS_W'(in_ready_v[0]),  BUS_W'(1));
    check("arst_valid",    BUS_W'(out_valid_v[0]), BUS_W'(0));
    check("arst_out",      out_shares_v[0],        '0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, {4{64'h4444_8888_2222_1111}}, lat, res);
    check("arst_recover_lat", BUS_W'(lat), BUS_W'(17));
    check("arst_recover_res", res, {4{64'h8888_5555_1111_3333}});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
